// File: rtl/ts_tx_pacer_pkg.sv
// ts_tx_pacer_pkg: shared widths, speed bit indices and slot-period decode for the TS pacer.
package ts_tx_pacer_pkg;
  localparam int TS_W = 128;
  localparam int GEN1_BIT = 0;
  localparam int GEN2_BIT = 1;
  localparam int GEN3_BIT = 2;
  localparam int GEN4_BIT = 3;
  localparam int GEN5_BIT = 4;
  localparam logic [6:0] TS_PERIOD_GEN1 = 7'd64;
  localparam logic [6:0] TS_PERIOD_GEN2 = 7'd32;
  localparam logic [6:0] TS_PERIOD_GEN3 = 7'd16;
  localparam logic [6:0] TS_PERIOD_GEN4 = 7'd8;
  localparam logic [6:0] TS_PERIOD_GEN5 = 7'd4;
  // Anything other than a single valid one-hot bit falls back to Gen1.
  function automatic logic [6:0] ts_period(input logic [5:0] speed);
    return speed == 6'(1 << GEN2_BIT) ? TS_PERIOD_GEN2 :
           speed == 6'(1 << GEN3_BIT) ? TS_PERIOD_GEN3 :
           speed == 6'(1 << GEN4_BIT) ? TS_PERIOD_GEN4 :
           speed == 6'(1 << GEN5_BIT) ? TS_PERIOD_GEN5 : TS_PERIOD_GEN1;
  endfunction
endpackage

// File: rtl/ts_tx_pacer_if.sv
// ts_tx_pacer_if: LTSSM-lane to pacer bundle; master is the LTSSM side, slave is the pacer.
interface ts_tx_pacer_if import ts_tx_pacer_pkg::*;;
  logic [TS_W-1:0] ts_in;
  logic            ts_in_vld;
  logic            tx_fifo_full;
  logic [5:0]      curr_speed;
  logic            ts_flush;
  logic [TS_W-1:0] ts_out;
  logic            ts_out_vld;
  logic            sent_enough;
  logic            overflow;
  modport master (output ts_in, ts_in_vld, curr_speed, ts_flush,
                  input tx_fifo_full, ts_out, ts_out_vld, sent_enough, overflow);
  modport slave (input ts_in, ts_in_vld, curr_speed, ts_flush,
                 output tx_fifo_full, ts_out, ts_out_vld, sent_enough, overflow);
endinterface

// File: rtl/ts_tx_pacer_fifo_sync.sv
// ts_fifo_sync: DEPTH-entry TS FIFO with wrapping pointers, occupancy count and synchronous flush.
module ts_fifo_sync import ts_tx_pacer_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [TS_W-1:0] wdata_i,
  output logic [TS_W-1:0] rdata_o,
  output logic            full_o,
  output logic            empty_o
);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  logic [TS_W-1:0] mem [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0] cnt_q, cnt_d;
  logic push_ok, pop_ok;
  assign full_o  = cnt_q == FULL_CNT;
  assign empty_o = cnt_q == '0;
  assign rdata_o = mem[rptr_q];
  always_comb begin
    push_ok = push_i & ~flush_i & ~full_o;
    pop_ok  = pop_i & ~flush_i & ~empty_o;
    wptr_d  = flush_i ? '0 : wptr_q + AW'(push_ok);
    rptr_d  = flush_i ? '0 : rptr_q + AW'(pop_ok);
    cnt_d   = flush_i ? '0 : cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr_q] <= wdata_i;
  end
endmodule

// File: rtl/ts_tx_pacer.sv
// ts_tx_pacer: per-lane TS buffer releasing one ordered set per line-rate slot, with
// backpressure, sticky overflow and sent-count status.
module ts_tx_pacer import ts_tx_pacer_pkg::*; #(
  parameter int DEPTH       = 4,
  parameter int AW          = 2,
  parameter int SENT_ENOUGH = 16
) (
  input logic           clk,
  input logic           rst,
  ts_tx_pacer_if.slave  bus
);
  localparam logic [15:0] SE_CNT = 16'(SENT_ENOUGH);
  logic [5:0] slot_q, slot_d;
  logic [6:0] reload;
  logic [TS_W-1:0] ts_out_q, ts_out_d, head;
  logic vld_q, vld_d, ovf_q, ovf_d, se_q, se_d;
  logic [15:0] sent_q, sent_d;
  logic boundary, pop, full, empty;
  ts_fifo_sync #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (bus.ts_flush),
    .push_i  (bus.ts_in_vld),
    .pop_i   (pop),
    .wdata_i (bus.ts_in),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );
  // The period is only sampled on reload, so a speed change waits for the current slot to end.
  always_comb begin
    reload   = ts_period(bus.curr_speed) - 7'd1;
    boundary = slot_q == '0;
    slot_d   = boundary ? reload[5:0] : slot_q - 6'd1;
    pop      = boundary & ~empty & ~bus.ts_flush;
    ts_out_d = pop ? head : ts_out_q;
    vld_d    = pop;
    ovf_d    = ovf_q | (bus.ts_in_vld & full & ~bus.ts_flush);
    sent_d   = bus.ts_flush ? '0 : (pop && sent_q != 16'hFFFF) ? sent_q + 16'd1 : sent_q;
    se_d     = ~bus.ts_flush & (sent_q >= SE_CNT);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q   <= 6'd63;
      ts_out_q <= '0;
      vld_q    <= 1'b0;
      ovf_q    <= 1'b0;
      sent_q   <= '0;
      se_q     <= 1'b0;
    end else begin
      slot_q   <= slot_d;
      ts_out_q <= ts_out_d;
      vld_q    <= vld_d;
      ovf_q    <= ovf_d;
      sent_q   <= sent_d;
      se_q     <= se_d;
    end
  end
  assign bus.ts_out       = ts_out_q;
  assign bus.ts_out_vld   = vld_q;
  assign bus.overflow     = ovf_q;
  assign bus.sent_enough  = se_q;
  assign bus.tx_fifo_full = full;
endmodule

// File: tb/tb_ts_tx_pacer.sv
// tb_ts_tx_pacer: randomized stimulus against a queue-based timeline model of the pacer.
module tb_ts_tx_pacer;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  ts_tx_pacer_if bus();
  ts_tx_pacer #(.DEPTH(DEPTH), .AW(2), .SENT_ENOUGH(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [127:0] q[$];
  int cyc, next_b, sent;
  logic [127:0] e_out;
  logic e_vld, e_full, e_se, e_ovf;
  logic [5:0] spd;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %h want %h", tag, cyc, act, exp);
    end
  endtask

  function automatic int period(input logic [5:0] s);
    if (s[5] || $countones(s) != 1) return 64;
    for (int k = 0; k < 5; k++) if (s[k]) return 64 >> k;
    return 64;
  endfunction

  task automatic model_reset();
    q.delete();
    sent = 0; cyc = 0; next_b = 63;
    e_out = '0; e_vld = 0; e_full = 0; e_se = 0; e_ovf = 0;
  endtask

  task automatic check_outputs(input string pfx);
    check({pfx, "_vld"}, 128'(bus.ts_out_vld), 128'(e_vld));
    check({pfx, "_out"}, bus.ts_out, e_out);
    check({pfx, "_full"}, 128'(bus.tx_fifo_full), 128'(e_full));
    check({pfx, "_se"}, 128'(bus.sent_enough), 128'(e_se));
    check({pfx, "_ovf"}, 128'(bus.overflow), 128'(e_ovf));
  endtask

  // Drive one cycle of inputs, predict the state after the next edge, then compare on the negedge.
  task automatic step(input logic wr, input logic fl);
    logic [127:0] d;
    logic was_full, bnd;
    d = {$urandom, $urandom, $urandom, $urandom};
    bus.ts_in = d; bus.ts_in_vld = wr; bus.ts_flush = fl; bus.curr_speed = spd;
    bnd = cyc == next_b;
    if (bnd) next_b = cyc + period(spd);
    was_full = q.size() == DEPTH;
    e_se = !fl && sent >= 16;
    e_vld = 0;
    if (bnd && !fl && q.size() > 0) begin
      e_out = q.pop_front();
      e_vld = 1;
      if (sent < 65535) sent++;
    end
    if (fl) begin
      q.delete();
      sent = 0;
    end else if (wr) begin
      if (was_full) e_ovf = 1;
      else q.push_back(d);
    end
    e_full = q.size() == DEPTH;
    cyc++;
    @(negedge clk);
    check_outputs("cyc");
  endtask

  task automatic run(input int n, input int wr_pct, input int spd_pct, input int fl_pct);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(99) < spd_pct) begin
        case ($urandom_range(7))
          5: spd = 6'h00;
          6: spd = 6'($urandom);
          7: spd = 6'h20;
          default: spd = 6'(1 << $urandom_range(4));
        endcase
      end
      step($urandom_range(99) < wr_pct, $urandom_range(999) < fl_pct);
    end
  endtask

  initial begin
    bus.ts_in = '0; bus.ts_in_vld = 0; bus.ts_flush = 0; bus.curr_speed = 6'h01;
    spd = 6'h01;
    model_reset();
    #2;
    check_outputs("rst");
    @(negedge clk);
    rst = 0;
    run(300, 3, 0, 0);
    spd = 6'h10;
    run(150, 60, 0, 0);
    step(1'b1, 1'b1);
    run(3000, 30, 2, 5);
    spd = 6'h04;
    run(40, 70, 0, 0);
    bus.ts_in_vld = 0;
    #3 rst = 1;
    #1 model_reset();
    check_outputs("arst");
    @(negedge clk);
    rst = 0;
    run(200, 0, 0, 0);
    run(500, 25, 2, 5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ts_tx_pacer.md
Name: ts_tx_pacer

Overview:
- Per-lane TX stage directly downstream of the LTSSM ts_gen output. One instance per lane.
- Buffers 128-bit TS1/TS2 ordered sets and releases them at the serial line rate of the current generation.
- Drives the lane tx_fifo_full backpressure input of the LTSSM, and reports sent-count status for the TS "sent enough" conditions.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- AW, 2, pointer width; equals log2(DEPTH).
- SENT_ENOUGH, 16, number of TSs released before sent_enough asserts.

Ports:
- clk  in  1  1GHz system clock.
- rst  in  1  reset; asynchronous, active-high.
- ts_in  in  128  TS from the LTSSM lane output.
- ts_in_vld  in  1  write strobe for ts_in.
- tx_fifo_full  out  1  backpressure to the LTSSM lane input.
- curr_speed  in  6  one-hot rate select: bit0=Gen1 .. bit4=Gen5; bit5 reserved.
- ts_flush  in  1  synchronous FIFO clear and sent-count clear.
- ts_out  out  128  TS released to the lane/serdes model.
- ts_out_vld  out  1  one-cycle release strobe.
- sent_enough  out  1  sent count is at least SENT_ENOUGH.
- overflow  out  1  sticky: a write arrived while full.

Behaviour:
- Reset values: ts_out=0, ts_out_vld=0, tx_fifo_full=0, sent_enough=0, overflow=0, FIFO empty, sent_cnt=0, slot_cnt=63.
- Slot period P from curr_speed: Gen1=64, Gen2=32, Gen3=16, Gen4=8, Gen5=4 cycles.
  - Zero, multi-hot, or bit5 set decodes as Gen1.
  - P is sampled only at slot reload. A speed change mid-slot takes effect on the following slot.
- Slot counter: free-running down-counter.
  - When slot_cnt==0 it is a slot boundary; it reloads P-1 on the next cycle, otherwise decrements.
- Release at a slot boundary with count>0:
  - Pop the head, register it onto ts_out, assert ts_out_vld for exactly one cycle (cycle after the boundary).
  - ts_out holds its last value otherwise.
  - An empty FIFO at the boundary gives no strobe; the slot is skipped, with no catch-up.
- Write: ts_in_vld with count<DEPTH pushes at the clock edge.
  - A write while full is dropped and sets overflow. overflow clears only on rst.
- tx_fifo_full: registered, equals (next count==DEPTH).
  - Full is visible the cycle after the push that fills the FIFO.
  - If that push lands on the DEPTH-th entry, the LTSSM must not issue another write in the same cycle the flag rises; such a write is dropped and flagged.
- Simultaneous push and pop:
  - count<DEPTH: both happen, count unchanged.
  - count==DEPTH: pop happens, push is dropped and sets overflow (full was already asserted).
- Empty FIFO at a boundary with a same-cycle push: the push is stored, no release; it is released at the next boundary.
  - Minimum write-to-out latency is therefore 2 cycles; maximum is P+1 cycles when the FIFO is otherwise empty.
- Pointers: AW-bit wrapping read/write pointers plus a count register of width AW+1.
- sent_cnt: 16-bit, increments on each release, saturates at 0xFFFF.
  - sent_enough is registered (sent_cnt>=SENT_ENOUGH).
- ts_flush:
  - Empties the FIFO, zeroes sent_cnt, deasserts sent_enough and tx_fifo_full the next cycle.
  - A release pending in that cycle is suppressed.
  - A write in the same cycle is discarded.
  - slot_cnt is unaffected.
- rst mid-operation: all state returns to reset values immediately (asynchronous); in-flight entries are lost.

Decomposition:
- Shared package:
  - speed one-hot bit indices (GEN1_BIT..GEN5_BIT)
  - slot period constants TS_PERIOD_GEN1..GEN5 (64/32/16/8/4)
  - TS width constant TS_W=128
  - speed-to-period decode function
- One natural sub-module: ts_fifo_sync.
  - Contents: DEPTH x TS_W storage, pointers, count, full/empty, flush.
- The pacer top holds the slot counter, release register, sent counter and flags.

Test Plan:
- Gen1, FIFO empty, one write at cycle 10 with slot_cnt=20 -> ts_out_vld at cycle 31; next release not before cycle 95; nothing in between.
- Gen5, 4 back-to-back writes -> tx_fifo_full rises the cycle after the 4th write; releases 4 cycles apart; full drops the cycle after the first pop.
- Gen3, FIFO full, write plus boundary pop in the same cycle -> pop occurs, write dropped, overflow=1, count goes 4 -> 3.
- Speed changed Gen1 -> Gen4 at slot_cnt=40 -> current slot completes at 64; subsequent periods are 8 cycles.
- SENT_ENOUGH=16 at Gen5 with continuous supply -> sent_enough asserts the cycle after the 16th ts_out_vld; ts_flush then clears it next cycle with sent_cnt=0.
- Async rst asserted mid-slot with 3 entries and overflow=1 -> all outputs 0 immediately; after release no ts_out_vld until a new write.
